// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX path.
package eth_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XMIT  = 2'd2,
    S_IFG   = 2'd3
  } tx_arb_state_t;

  localparam int unsigned ETH_IFG_BYTES     = 12;
  localparam int unsigned ETH_START_TIMEOUT = 64;
  localparam int unsigned ETH_MAX_FRAME     = 1530;
  localparam int unsigned ETH_CNT_W         = 11;

  // Preamble + SFD, first byte on the wire in bits [7:0].
  localparam logic [63:0] ETH_PREAMBLE_SFD = 64'hD555_5555_5555_5555;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at/after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned k;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (!valid_o && req_i[IDX_W'(k)]) begin
        grant_o[IDX_W'(k)] = 1'b1;
        idx_o              = IDX_W'(k);
        valid_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one 8-bit Ethernet TX byte path between NUM_REQ frame generators:
// round-robin, one frame per grant, enforced inter-frame gap, start/overrun watchdog.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned IFG_BYTES     = ETH_IFG_BYTES,
  parameter int unsigned START_TIMEOUT = ETH_START_TIMEOUT,
  parameter int unsigned MAX_FRAME     = ETH_MAX_FRAME
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     i_req,
  output logic [NUM_REQ-1:0]     o_grant,
  input  logic [8*NUM_REQ-1:0]   i_data,
  input  logic [NUM_REQ-1:0]     i_tx_en,
  output logic [7:0]             o_data,
  output logic                   o_tx_en,
  output logic                   o_busy,
  output logic                   o_err_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = ETH_CNT_W;

  tx_arb_state_t      state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] lock_q, lock_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               tx_en_q, tx_en_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               sel_tx_en;
  logic               sel_req;
  logic [7:0]         sel_data;

  // Locked requesters overran MAX_FRAME and must drop i_req before competing again.
  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (i_req & ~lock_q),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_tx_en = i_tx_en[idx_q];
  assign sel_req   = i_req[idx_q];
  assign sel_data  = i_data[{idx_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      lock_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      tx_en_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tx_en_q <= tx_en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // cnt_q is reused: start-wait clocks in S_GRANT, bytes sent in S_XMIT, gap clocks in S_IFG.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lock_d  = lock_q & i_req;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = 8'h00;
    tx_en_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          idx_d   = arb_idx;
          ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (sel_tx_en) begin
          data_d  = sel_data;
          tx_en_d = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_XMIT;
        end else if (!sel_req) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          grant_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IFG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XMIT: begin
        if (!sel_tx_en) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = S_IFG;
        end else if (cnt_q == CNT_W'(MAX_FRAME)) begin
          grant_d       = '0;
          lock_d[idx_q] = 1'b1;
          err_d         = 1'b1;
          cnt_d         = '0;
          state_d       = S_IFG;
        end else begin
          data_d  = sel_data;
          tx_en_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_IFG: begin
        if (cnt_q == CNT_W'(IFG_BYTES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_grant       = grant_q;
  assign o_data        = data_q;
  assign o_tx_en       = tx_en_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;

endmodule
